// File: rtl/pipe_datapath_memory_lsu.sv
// Memory stage of the RV32I pipeline: EX/MEM register, req/gnt/rvalid data bus, lane steering.
// Optional misaligned-access trap is enabled by defining PIPE_MEM_MISALIGN_CHK_EN.
module pipe_datapath_memory_lsu #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [XLEN-1:0] i_dp_ALUE,
  input  logic [XLEN-1:0] i_dp_WriteDataE,
  input  logic [XLEN-1:0] i_dp_PC_Plus4E,
  input  logic [4:0]      i_dp_RdE,
  input  logic            i_dp_RegWriteE,
  input  logic            i_dp_MemWriteE,
  input  logic            i_dp_MemReadE,
  input  logic [1:0]      i_dp_ResultSrcE,
  input  logic [2:0]      i_dp_funct3E,
  output logic            o_dmem_req,
  output logic            o_dmem_we,
  output logic [XLEN-1:0] o_dmem_addr,
  output logic [XLEN-1:0] o_dmem_wdata,
  output logic [3:0]      o_dmem_be,
  input  logic            i_dmem_gnt,
  input  logic            i_dmem_rvalid,
  input  logic [XLEN-1:0] i_dmem_rdata,
  output logic [XLEN-1:0] o_dp_ALUM,
  output logic [XLEN-1:0] o_dp_ReadDataM,
  output logic [4:0]      o_dp_RdM,
  output logic            o_dp_RegWriteM,
  output logic [1:0]      o_dp_ResultSrcM,
  output logic [XLEN-1:0] o_dp_PC_Plus4M,
  output logic            o_stall_mem,
  output logic            o_err_bus,
  output logic            o_err_misalign
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;
  localparam logic [7:0] LP_CNT_LAST = 8'(MAX_WAIT - 1);

  logic [1:0]      r_state;
  logic [7:0]      r_cnt;
  logic [XLEN-1:0] r_alu, r_wdata, r_pc4, r_rdata;
  logic [4:0]      r_rd;
  logic            r_regwrite, r_memwrite;
  logic [1:0]      r_resultsrc;
  logic [2:0]      r_funct3;
  logic            r_err_bus, r_err_mis;

  logic            w_capture, w_mem_e, w_misalign_e, w_req, w_timeout;
  logic [3:0]      w_be;
  logic [XLEN-1:0] w_wdata, w_shift, w_ext;

  assign w_capture = (r_state == S_IDLE) || (r_state == S_DONE);
  assign w_mem_e   = i_dp_MemReadE | i_dp_MemWriteE;
  assign w_req     = (r_state == S_REQ);
  // Timeout fires on the MAX_WAIT-th WAIT cycle (counter holds completed WAIT cycles).
  assign w_timeout = (r_cnt == LP_CNT_LAST);

`ifdef PIPE_MEM_MISALIGN_CHK_EN
  assign w_misalign_e = w_mem_e &
      (((i_dp_funct3E[1:0] == 2'b01) & i_dp_ALUE[0]) |
       ((i_dp_funct3E[1:0] == 2'b10) & (i_dp_ALUE[1:0] != 2'b00)));
`else
  assign w_misalign_e = 1'b0;
`endif

  assign w_shift = i_dmem_rdata >> {r_alu[1:0], 3'b000};

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = r_wdata;
    w_ext   = i_dmem_rdata;
    case (r_funct3[1:0])
      2'b00: begin
        w_be    = 4'b0001 << r_alu[1:0];
        w_wdata = {4{r_wdata[7:0]}};
        w_ext   = {{(XLEN-8){~r_funct3[2] & w_shift[7]}}, w_shift[7:0]};
      end
      2'b01: begin
        w_be    = 4'b0011 << r_alu[1:0];
        w_wdata = {2{r_wdata[15:0]}};
        w_ext   = {{(XLEN-16){~r_funct3[2] & w_shift[15]}}, w_shift[15:0]};
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_alu       <= '0;
      r_wdata     <= '0;
      r_pc4       <= '0;
      r_rdata     <= '0;
      r_rd        <= '0;
      r_regwrite  <= 1'b0;
      r_memwrite  <= 1'b0;
      r_resultsrc <= '0;
      r_funct3    <= '0;
      r_err_bus   <= 1'b0;
      r_err_mis   <= 1'b0;
    end else begin
      r_err_bus <= 1'b0;
      r_err_mis <= 1'b0;
      case (r_state)
        S_REQ: begin
          if (i_dmem_gnt) begin
            r_cnt   <= '0;
            r_state <= r_memwrite ? S_DONE : S_WAIT;
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt + 8'd1;
          if (i_dmem_rvalid) begin
            r_rdata <= w_ext;
            r_state <= S_DONE;
          end else if (w_timeout) begin
            r_rdata   <= '0;
            r_err_bus <= 1'b1;
            r_state   <= S_DONE;
          end
        end
        default: begin
          // IDLE/DONE: capture edge, stray gnt/rvalid ignored.
          r_alu       <= i_dp_ALUE;
          r_wdata     <= i_dp_WriteDataE;
          r_pc4       <= i_dp_PC_Plus4E;
          r_rd        <= i_dp_RdE;
          r_regwrite  <= i_dp_RegWriteE & ~w_misalign_e;
          r_memwrite  <= i_dp_MemWriteE;
          r_resultsrc <= i_dp_ResultSrcE;
          r_funct3    <= i_dp_funct3E;
          r_rdata     <= '0;
          r_cnt       <= '0;
          if (w_misalign_e) begin
            r_err_mis <= 1'b1;
            r_state   <= S_DONE;
          end else if (w_mem_e) begin
            r_state <= S_REQ;
          end else begin
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign o_dmem_req      = w_req;
  assign o_dmem_we       = w_req & r_memwrite;
  assign o_dmem_addr     = w_req ? {r_alu[XLEN-1:2], 2'b00} : '0;
  assign o_dmem_be       = w_req ? w_be : 4'b0000;
  assign o_dmem_wdata    = (w_req & r_memwrite) ? w_wdata : '0;
  assign o_dp_ALUM       = r_alu;
  assign o_dp_ReadDataM  = r_rdata;
  assign o_dp_RdM        = r_rd;
  assign o_dp_RegWriteM  = r_regwrite;
  assign o_dp_ResultSrcM = r_resultsrc;
  assign o_dp_PC_Plus4M  = r_pc4;
  assign o_stall_mem     = w_req || (r_state == S_WAIT);
  assign o_err_bus       = r_err_bus;
  assign o_err_misalign  = r_err_mis;

  logic w_unused;
  assign w_unused = w_capture;

endmodule

// File: tb/tb_pipe_datapath_memory_lsu.sv
// Directed bench for pipe_datapath_memory_lsu; build with PIPE_MEM_MISALIGN_CHK_EN to
// exercise the misalignment trap instead of the pass-through behaviour.
module tb_pipe_datapath_memory_lsu;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [31:0] i_dp_ALUE, i_dp_WriteDataE, i_dp_PC_Plus4E;
  logic [4:0]  i_dp_RdE;
  logic        i_dp_RegWriteE, i_dp_MemWriteE, i_dp_MemReadE;
  logic [1:0]  i_dp_ResultSrcE;
  logic [2:0]  i_dp_funct3E;
  logic        o_dmem_req, o_dmem_we;
  logic [31:0] o_dmem_addr, o_dmem_wdata;
  logic [3:0]  o_dmem_be;
  logic        i_dmem_gnt, i_dmem_rvalid;
  logic [31:0] i_dmem_rdata;
  logic [31:0] o_dp_ALUM, o_dp_ReadDataM, o_dp_PC_Plus4M;
  logic [4:0]  o_dp_RdM;
  logic        o_dp_RegWriteM;
  logic [1:0]  o_dp_ResultSrcM;
  logic        o_stall_mem, o_err_bus, o_err_misalign;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] b_addr, b_wdata;
  logic [3:0]  b_be;
  logic        b_we, b_req_seen;
  int          st;

  always #5 i_clk = ~i_clk;

  pipe_datapath_memory_lsu #(.XLEN(32), .MAX_WAIT(15)) dut (
    .i_clk           (i_clk),
    .i_rst           (i_rst),
    .i_dp_ALUE       (i_dp_ALUE),
    .i_dp_WriteDataE (i_dp_WriteDataE),
    .i_dp_PC_Plus4E  (i_dp_PC_Plus4E),
    .i_dp_RdE        (i_dp_RdE),
    .i_dp_RegWriteE  (i_dp_RegWriteE),
    .i_dp_MemWriteE  (i_dp_MemWriteE),
    .i_dp_MemReadE   (i_dp_MemReadE),
    .i_dp_ResultSrcE (i_dp_ResultSrcE),
    .i_dp_funct3E    (i_dp_funct3E),
    .o_dmem_req      (o_dmem_req),
    .o_dmem_we       (o_dmem_we),
    .o_dmem_addr     (o_dmem_addr),
    .o_dmem_wdata    (o_dmem_wdata),
    .o_dmem_be       (o_dmem_be),
    .i_dmem_gnt      (i_dmem_gnt),
    .i_dmem_rvalid   (i_dmem_rvalid),
    .i_dmem_rdata    (i_dmem_rdata),
    .o_dp_ALUM       (o_dp_ALUM),
    .o_dp_ReadDataM  (o_dp_ReadDataM),
    .o_dp_RdM        (o_dp_RdM),
    .o_dp_RegWriteM  (o_dp_RegWriteM),
    .o_dp_ResultSrcM (o_dp_ResultSrcM),
    .o_dp_PC_Plus4M  (o_dp_PC_Plus4M),
    .o_stall_mem     (o_stall_mem),
    .o_err_bus       (o_err_bus),
    .o_err_misalign  (o_err_misalign)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic nop_inputs();
    i_dp_ALUE       = '0;
    i_dp_WriteDataE = '0;
    i_dp_PC_Plus4E  = '0;
    i_dp_RdE        = '0;
    i_dp_RegWriteE  = 1'b0;
    i_dp_MemWriteE  = 1'b0;
    i_dp_MemReadE   = 1'b0;
    i_dp_ResultSrcE = '0;
    i_dp_funct3E    = '0;
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Issue one memory op, then play the bus: gnt on REQ cycle gnt_dly, rvalid rv_dly cycles
  // after gnt (rv_dly < 0: never). Returns with the DUT sampled in its first unstalled cycle.
  task automatic mem_op(input logic [31:0] addr, input logic [31:0] data, input logic we,
                        input logic [2:0] f3, input int gnt_dly, input int rv_dly,
                        input logic [31:0] rdata, output int stalls);
    int k;
    int g_at;
    i_dp_ALUE       = addr;
    i_dp_WriteDataE = data;
    i_dp_PC_Plus4E  = addr + 32'd4;
    i_dp_RdE        = 5'd10;
    i_dp_MemWriteE  = we;
    i_dp_MemReadE   = ~we;
    i_dp_RegWriteE  = ~we;
    i_dp_ResultSrcE = we ? 2'b00 : 2'b01;
    i_dp_funct3E    = f3;
    i_dmem_rdata    = rdata;
    tick();
    nop_inputs();
    stalls     = 0;
    k          = 0;
    g_at       = -1000;
    b_req_seen = 1'b0;
    while (o_stall_mem && k < 60) begin
      stalls++;
      if (o_dmem_req) begin
        if (!b_req_seen) begin
          b_addr     = o_dmem_addr;
          b_wdata    = o_dmem_wdata;
          b_be       = o_dmem_be;
          b_we       = o_dmem_we;
          b_req_seen = 1'b1;
        end
        i_dmem_gnt    = (k == gnt_dly);
        i_dmem_rvalid = 1'b0;
        if (k == gnt_dly) g_at = k;
      end else begin
        i_dmem_gnt    = 1'b0;
        i_dmem_rvalid = (rv_dly >= 0) && (k - g_at == rv_dly);
      end
      k++;
      tick();
    end
    i_dmem_gnt    = 1'b0;
    i_dmem_rvalid = 1'b0;
    if (k >= 60) check("op_cycle_bound", 32'(o_stall_mem), 32'd0);
  endtask

  initial begin
    nop_inputs();
    i_rst         = 1'b1;
    i_dmem_gnt    = 1'b0;
    i_dmem_rvalid = 1'b0;
    i_dmem_rdata  = '0;
    tick();
    tick();
    check("rst_req", 32'(o_dmem_req), 32'd0);
    check("rst_stall", 32'(o_stall_mem), 32'd0);
    check("rst_be", 32'(o_dmem_be), 32'd0);
    check("rst_alum", o_dp_ALUM, 32'd0);
    check("rst_rdata", o_dp_ReadDataM, 32'd0);
    check("rst_regwr", 32'(o_dp_RegWriteM), 32'd0);
    check("rst_errbus", 32'(o_err_bus), 32'd0);
    i_rst = 1'b0;

    // Non-memory op: single cycle, forwarding fields registered
    i_dp_ALUE       = 32'h1234_5678;
    i_dp_RdE        = 5'd5;
    i_dp_RegWriteE  = 1'b1;
    i_dp_ResultSrcE = 2'b10;
    i_dp_PC_Plus4E  = 32'h0000_0044;
    tick();
    nop_inputs();
    check("alu_alum", o_dp_ALUM, 32'h1234_5678);
    check("alu_rd", 32'(o_dp_RdM), 32'd5);
    check("alu_regwr", 32'(o_dp_RegWriteM), 32'd1);
    check("alu_rsrc", 32'(o_dp_ResultSrcM), 32'd2);
    check("alu_pc4", o_dp_PC_Plus4M, 32'h0000_0044);
    check("alu_stall", 32'(o_stall_mem), 32'd0);

    // SB 0xA5 @0x103
    mem_op(32'h103, 32'h0000_00A5, 1'b1, 3'b000, 0, -1, 32'h0, st);
    check("sb_be", 32'(b_be), 32'h8);
    check("sb_wdata", b_wdata, 32'hA5A5_A5A5);
    check("sb_we", 32'(b_we), 32'd1);
    check("sb_addr", b_addr, 32'h100);
    check("sb_stalls", 32'(st), 32'd1);
    check("sb_done_req", 32'(o_dmem_req), 32'd0);

    // LB @0x102, rvalid 2 cycles after gnt
    mem_op(32'h102, 32'h0, 1'b0, 3'b000, 0, 2, 32'h0080_0000, st);
    check("lb_data", o_dp_ReadDataM, 32'hFFFF_FF80);
    check("lb_stalls", 32'(st), 32'd3);
    check("lb_be", 32'(b_be), 32'h4);
    check("lb_we", 32'(b_we), 32'd0);
    check("lb_alum", o_dp_ALUM, 32'h102);
    check("lb_regwr", 32'(o_dp_RegWriteM), 32'd1);
    check("lb_rsrc", 32'(o_dp_ResultSrcM), 32'd1);

    mem_op(32'h102, 32'h0, 1'b0, 3'b101, 0, 1, 32'h8001_0000, st);
    check("lhu_data", o_dp_ReadDataM, 32'h0000_8001);
    check("lhu_be", 32'(b_be), 32'hC);
    check("lhu_stalls", 32'(st), 32'd2);

    mem_op(32'h102, 32'h0, 1'b0, 3'b001, 0, 1, 32'h8001_0000, st);
    check("lh_data", o_dp_ReadDataM, 32'hFFFF_8001);

    mem_op(32'h101, 32'h0, 1'b0, 3'b100, 0, 1, 32'h0000_F100, st);
    check("lbu_data", o_dp_ReadDataM, 32'h0000_00F1);
    check("lbu_be", 32'(b_be), 32'h2);

    mem_op(32'h102, 32'h1234_ABCD, 1'b1, 3'b001, 1, -1, 32'h0, st);
    check("sh_be", 32'(b_be), 32'hC);
    check("sh_wdata", b_wdata, 32'hABCD_ABCD);
    check("sh_stalls", 32'(st), 32'd2);

    mem_op(32'h104, 32'hCAFE_F00D, 1'b1, 3'b010, 0, -1, 32'h0, st);
    check("sw_be", 32'(b_be), 32'hF);
    check("sw_wdata", b_wdata, 32'hCAFE_F00D);
    check("sw_addr", b_addr, 32'h104);

    // LW: gnt after 3 REQ cycles, never rvalid -> timeout after 15 WAIT cycles
    mem_op(32'h200, 32'h0, 1'b0, 3'b010, 3, -1, 32'hDEAD_BEEF, st);
    check("to_stalls", 32'(st), 32'd19);
    check("to_errbus", 32'(o_err_bus), 32'd1);
    check("to_data", o_dp_ReadDataM, 32'h0);
    tick();
    check("to_errbus_pulse", 32'(o_err_bus), 32'd0);

    mem_op(32'h204, 32'h0, 1'b0, 3'b010, 0, 1, 32'hDEAD_BEEF, st);
    check("lw_data", o_dp_ReadDataM, 32'hDEAD_BEEF);
    check("lw_errbus", 32'(o_err_bus), 32'd0);

    mem_op(32'h101, 32'h0, 1'b0, 3'b010, 0, 1, 32'h5555_AAAA, st);
`ifdef PIPE_MEM_MISALIGN_CHK_EN
    check("mis_stalls", 32'(st), 32'd0);
    check("mis_noreq", 32'(b_req_seen), 32'd0);
    check("mis_err", 32'(o_err_misalign), 32'd1);
    check("mis_regwr", 32'(o_dp_RegWriteM), 32'd0);
    check("mis_data", o_dp_ReadDataM, 32'h0);
    tick();
    check("mis_err_pulse", 32'(o_err_misalign), 32'd0);
`else
    check("mis_req", 32'(b_req_seen), 32'd1);
    check("mis_be", 32'(b_be), 32'hF);
    check("mis_addr", b_addr, 32'h100);
    check("mis_err", 32'(o_err_misalign), 32'd0);
    check("mis_regwr", 32'(o_dp_RegWriteM), 32'd1);
    tick();
`endif

    // Stray gnt/rvalid while idle
    tick();
    i_dmem_gnt    = 1'b1;
    i_dmem_rvalid = 1'b1;
    i_dmem_rdata  = 32'h7777_7777;
    tick();
    i_dmem_gnt    = 1'b0;
    i_dmem_rvalid = 1'b0;
    check("idle_stall", 32'(o_stall_mem), 32'd0);
    check("idle_req", 32'(o_dmem_req), 32'd0);
    check("idle_data", o_dp_ReadDataM, 32'h0);

    // Reset while a load sits in WAIT
    i_dp_ALUE      = 32'h300;
    i_dp_MemReadE  = 1'b1;
    i_dp_RegWriteE = 1'b1;
    i_dp_funct3E   = 3'b010;
    tick();
    nop_inputs();
    check("rw_req", 32'(o_dmem_req), 32'd1);
    i_dmem_gnt = 1'b1;
    tick();
    i_dmem_gnt = 1'b0;
    check("rw_wait_stall", 32'(o_stall_mem), 32'd1);
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    check("rw_req_after", 32'(o_dmem_req), 32'd0);
    check("rw_stall_after", 32'(o_stall_mem), 32'd0);
    check("rw_alum_after", o_dp_ALUM, 32'h0);
    i_dmem_rvalid = 1'b1;
    i_dmem_rdata  = 32'h1111_1111;
    tick();
    i_dmem_rvalid = 1'b0;
    check("rw_late_stall", 32'(o_stall_mem), 32'd0);
    check("rw_late_data", o_dp_ReadDataM, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
